// File: rtl/debug_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : debug_controller_if
// Brief    : Host-link, pipeline-control and debug-bus signals of the debug
//            controller, grouped for connection between host side and pipeline.
// Revision : 1.0 - initial release
// ============================================================================
interface debug_controller_if #(
    parameter int NB_REG       = 32,
    parameter int NB_BYTE      = 8,
    parameter int NB_DUMP_ADDR = 6
);
    logic [NB_BYTE-1:0]      i_rx_data;
    logic                    i_rx_valid;
    logic                    i_halt;
    logic [NB_REG-1:0]       i_dbg_data;
    logic                    i_tx_ready;
    logic                    o_pipe_valid;
    logic                    o_pipe_reset;
    logic [NB_DUMP_ADDR-1:0] o_dbg_addr;
    logic [NB_BYTE-1:0]      o_tx_data;
    logic                    o_tx_valid;
    logic                    o_busy;

    modport slave (
        input  i_rx_data, i_rx_valid, i_halt, i_dbg_data, i_tx_ready,
        output o_pipe_valid, o_pipe_reset, o_dbg_addr, o_tx_data, o_tx_valid, o_busy
    );

    modport master (
        output i_rx_data, i_rx_valid, i_halt, i_dbg_data, i_tx_ready,
        input  o_pipe_valid, o_pipe_reset, o_dbg_addr, o_tx_data, o_tx_valid, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/debug_controller.sv
`default_nettype none
// ============================================================================
// Module   : debug_controller
// Brief    : Run/step sequencer for the MIPS pipeline with cycle counting and
//            byte-serial register dump over the host link.
// Revision : 1.0 - initial release
// ============================================================================
module debug_controller #(
    parameter int NB_REG       = 32,
    parameter int NB_BYTE      = 8,
    parameter int N_DUMP_WORDS = 33,
    parameter int NB_DUMP_ADDR = 6
) (
    input  wire logic        i_clock,
    input  wire logic        i_reset,
    debug_controller_if.slave bus
);
    localparam int C_BYTES_PER_WORD = NB_REG / NB_BYTE;
    localparam int C_NB_BIDX        = (C_BYTES_PER_WORD > 1) ? $clog2(C_BYTES_PER_WORD) : 1;
    localparam int C_NB_WIDX        = (N_DUMP_WORDS > 1) ? $clog2(N_DUMP_WORDS) : 1;

    localparam logic [NB_BYTE-1:0]   C_CMD_RUN     = NB_BYTE'(8'h43);
    localparam logic [NB_BYTE-1:0]   C_CMD_STEP    = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0]   C_CMD_RESTART = NB_BYTE'(8'h52);
    localparam logic [C_NB_BIDX-1:0] C_LAST_BYTE   = C_NB_BIDX'(C_BYTES_PER_WORD - 1);
    localparam logic [C_NB_WIDX-1:0] C_LAST_WORD   = C_NB_WIDX'(N_DUMP_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RUN        = 3'd1,
        S_STEP       = 3'd2,
        S_DUMP_ADDR  = 3'd3,
        S_DUMP_LATCH = 3'd4,
        S_DUMP_SEND  = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    state_t                 ret_q, ret_d;
    logic [NB_REG-1:0]      cnt_q, cnt_d;
    logic [NB_REG-1:0]      shreg_q, shreg_d;
    logic [C_NB_BIDX-1:0]   byte_q, byte_d;
    logic [C_NB_WIDX-1:0]   word_q, word_d;
    logic                   pipe_reset_q, pipe_reset_d;

    logic                   w_cmd_run;
    logic                   w_cmd_step;
    logic                   w_cmd_restart;
    logic [NB_REG-1:0]      w_cnt_inc;

    assign w_cmd_run     = bus.i_rx_valid && (bus.i_rx_data == C_CMD_RUN);
    assign w_cmd_step    = bus.i_rx_valid && (bus.i_rx_data == C_CMD_STEP);
    assign w_cmd_restart = bus.i_rx_valid && (bus.i_rx_data == C_CMD_RESTART);

    // Saturating increment: a long free run must never wrap back to a small count.
    assign w_cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + NB_REG'(1);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            ret_q        <= S_IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            byte_q       <= '0;
            word_q       <= '0;
            pipe_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            byte_q       <= byte_d;
            word_q       <= word_d;
            pipe_reset_q <= pipe_reset_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        byte_d       = byte_q;
        word_d       = word_q;
        pipe_reset_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_cmd_restart) begin
                    pipe_reset_d = 1'b1;
                    cnt_d        = '0;
                end else if (w_cmd_run) begin
                    state_d = S_RUN;
                end else if (w_cmd_step) begin
                    state_d = S_STEP;
                end
            end

            S_RUN: begin
                cnt_d = w_cnt_inc;
                if (bus.i_halt) begin
                    ret_d   = S_DONE;
                    state_d = S_DUMP_ADDR;
                    word_d  = '0;
                    byte_d  = '0;
                end
            end

            S_STEP: begin
                cnt_d   = w_cnt_inc;
                ret_d   = bus.i_halt ? S_DONE : S_IDLE;
                state_d = S_DUMP_ADDR;
                word_d  = '0;
                byte_d  = '0;
            end

            S_DUMP_ADDR: begin
                state_d = S_DUMP_LATCH;
            end

            // Debug read data arrives one cycle after the address was presented.
            S_DUMP_LATCH: begin
                shreg_d = (word_q == '0) ? cnt_q : bus.i_dbg_data;
                byte_d  = '0;
                state_d = S_DUMP_SEND;
            end

            S_DUMP_SEND: begin
                if (bus.i_tx_ready) begin
                    if (byte_q == C_LAST_BYTE) begin
                        byte_d = '0;
                        if (word_q == C_LAST_WORD) begin
                            word_d  = '0;
                            state_d = ret_q;
                        end else begin
                            word_d  = word_q + C_NB_WIDX'(1);
                            state_d = S_DUMP_ADDR;
                        end
                    end else begin
                        shreg_d = shreg_q >> NB_BYTE;
                        byte_d  = byte_q + C_NB_BIDX'(1);
                    end
                end
            end

            S_DONE: begin
                if (w_cmd_restart) begin
                    pipe_reset_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.o_pipe_valid = (state_q == S_RUN) || (state_q == S_STEP);
    assign bus.o_pipe_reset = pipe_reset_q;
    assign bus.o_dbg_addr   = ((state_q == S_DUMP_ADDR) && (word_q != '0))
                            ? NB_DUMP_ADDR'(word_q - C_NB_WIDX'(1)) : '0;
    assign bus.o_tx_valid   = (state_q == S_DUMP_SEND);
    assign bus.o_tx_data    = (state_q == S_DUMP_SEND) ? shreg_q[NB_BYTE-1:0] : '0;
    assign bus.o_busy       = (state_q != S_IDLE) && (state_q != S_DONE);
endmodule
`default_nettype wire

// File: tb/tb_debug_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_controller
// Brief    : Randomized scoreboard bench for debug_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_controller;
    localparam int NB_REG       = 32;
    localparam int NB_BYTE      = 8;
    localparam int N_DUMP_WORDS = 33;
    localparam int NB_DUMP_ADDR = 6;
    localparam int DUMP_BYTES   = N_DUMP_WORDS * (NB_REG / NB_BYTE);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    debug_controller_if #(.NB_REG(NB_REG), .NB_BYTE(NB_BYTE), .NB_DUMP_ADDR(NB_DUMP_ADDR)) bus ();

    debug_controller #(
        .NB_REG(NB_REG), .NB_BYTE(NB_BYTE),
        .N_DUMP_WORDS(N_DUMP_WORDS), .NB_DUMP_ADDR(NB_DUMP_ADDR)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus(bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    int          n_acc = 0;
    int          vcnt = 0;
    int          rcnt = 0;
    int          bp_mode = 0;
    int          stall_cnt = 0;
    logic [31:0] model_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected dump: cycle count, then debug word a = a*0x01010101, all LSB first.
    task automatic push_dump(input logic [31:0] count);
        logic [31:0] w;
        for (int k = 0; k < N_DUMP_WORDS; k++) begin
            w = (k == 0) ? count : (32'(k - 1) * 32'h01010101);
            for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
        end
    endtask

    always @(posedge clk) bus.i_dbg_data <= 32'(bus.o_dbg_addr) * 32'h01010101;

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0: bus.i_tx_ready = 1'b1;
            1: bus.i_tx_ready = 1'($urandom_range(0, 1));
            default: begin
                if (bus.o_tx_valid) begin
                    if (stall_cnt == 5) begin
                        bus.i_tx_ready = 1'b1;
                        stall_cnt = 0;
                    end else begin
                        bus.i_tx_ready = 1'b0;
                        stall_cnt++;
                    end
                end else begin
                    bus.i_tx_ready = 1'b0;
                    stall_cnt = 0;
                end
            end
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.o_pipe_valid) vcnt++;
            if (bus.o_pipe_reset) rcnt++;
            chk("pv_pr_exclusive", 32'(bus.o_pipe_valid & bus.o_pipe_reset), 0);
            if (prev_stall) begin
                chk("tx_hold_valid", 32'(bus.o_tx_valid), 1);
                chk("tx_hold_data", 32'(bus.o_tx_data), 32'(prev_data));
            end
            if (bus.o_tx_valid && bus.i_tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL tx_extra: got byte %0h, expected no byte", bus.o_tx_data);
                end else begin
                    chk("tx_byte", 32'(bus.o_tx_data), 32'(exp_q.pop_front()));
                end
                n_acc++;
            end
            prev_stall = bus.o_tx_valid && !bus.i_tx_ready;
            prev_data  = bus.o_tx_data;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        cyc(1);
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_pipe_valid"}, 32'(bus.o_pipe_valid), 0);
        chk({tag, "_pipe_reset"}, 32'(bus.o_pipe_reset), 0);
        chk({tag, "_dbg_addr"},   32'(bus.o_dbg_addr), 0);
        chk({tag, "_tx_data"},    32'(bus.o_tx_data), 0);
        chk({tag, "_tx_valid"},   32'(bus.o_tx_valid), 0);
        chk({tag, "_busy"},       32'(bus.o_busy), 0);
    endtask

    task automatic wait_dump(input string tag, input int a0);
        int k = 0;
        while ((exp_q.size() != 0 || bus.o_busy) && k < 20000) begin
            cyc(1);
            k++;
        end
        if (k >= 20000) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got %0d bytes pending, expected 0", tag, exp_q.size());
        end
        chk({tag, "_bytes"}, 32'(n_acc - a0), DUMP_BYTES);
        chk({tag, "_busy_after"}, 32'(bus.o_busy), 0);
    endtask

    task automatic do_step(input bit with_halt);
        int v0 = vcnt;
        int a0 = n_acc;
        model_cnt = model_cnt + 1;
        push_dump(model_cnt);
        send(8'h53);
        if (with_halt) begin
            bus.i_halt = 1'b1;
            cyc(1);
            bus.i_halt = 1'b0;
        end
        wait_dump("step", a0);
        chk("step_valid_cycles", 32'(vcnt - v0), 1);
    endtask

    task automatic do_run(input int n, input bit inject);
        int v0 = vcnt;
        int a0 = n_acc;
        int k = 0;
        model_cnt = model_cnt + 32'(n);
        push_dump(model_cnt);
        send(8'h43);
        if (inject) send(8'h53);
        while (k < 5000) begin
            @(negedge clk);
            #1;
            if (vcnt - v0 >= n) break;
            k++;
        end
        bus.i_halt = 1'b1;
        cyc(1);
        bus.i_halt = 1'b0;
        wait_dump("run", a0);
        chk("run_valid_cycles", 32'(vcnt - v0), 32'(n));
    endtask

    task automatic check_ignored(input logic [7:0] b, input string tag);
        int v0 = vcnt;
        send(b);
        cyc(10);
        chk({tag, "_no_valid"}, 32'(vcnt - v0), 0);
        chk({tag, "_not_busy"}, 32'(bus.o_busy), 0);
    endtask

    task automatic restart();
        int r0 = rcnt;
        send(8'h52);
        cyc(2);
        chk("restart_pulses", 32'(rcnt - r0), 1);
        model_cnt = 0;
    endtask

    task automatic do_reset();
        cyc(1);
        rst = 1'b1;
        exp_q.delete();
        cyc(1);
        chk_reset_outs("rst");
        cyc(1);
        rst = 1'b0;
        model_cnt = 0;
    endtask

    initial begin
        logic [7:0] junk;
        int         a0;
        int         k;
        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b0;
        bus.i_halt     = 1'b0;
        bus.i_tx_ready = 1'b0;
        cyc(3);
        chk_reset_outs("por");
        rst = 1'b0;

        bp_mode = 0;
        do_step(1'b0);

        do_reset();
        do_run(10, 1'b0);
        check_ignored(8'h43, "done_C");
        check_ignored(8'h53, "done_S");

        restart();
        do_step(1'b0);

        bp_mode = 2;
        do_step(1'b0);
        bp_mode = 1;

        model_cnt = model_cnt + 1;
        push_dump(model_cnt);
        a0 = n_acc;
        send(8'h53);
        k = 0;
        while (n_acc - a0 < 50 && k < 5000) begin
            cyc(1);
            k++;
        end
        chk("middump_reached", 32'(n_acc - a0 >= 50), 1);
        do_reset();
        do_step(1'b0);

        bp_mode = 0;
        do_run($urandom_range(6, 20), 1'b1);
        restart();
        check_ignored(8'h41, "idle_A");

        do_step(1'b1);
        check_ignored(8'h43, "stephalt_C");
        restart();

        for (int it = 0; it < 8; it++) begin
            bp_mode = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1) begin
                do_run($urandom_range(2, 30), 1'($urandom_range(0, 1)) & 1'b0);
                restart();
            end else begin
                do_step(1'b0);
            end
            junk = 8'($urandom_range(0, 255));
            if (junk != 8'h43 && junk != 8'h53 && junk != 8'h52)
                check_ignored(junk, "rand_junk");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
